// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control sequencer: fetch/decode/execute/resolve/mem/writeback with shared memory-port handshake.
// Strobes are combinational from state (ir_load and MEM-exit rf_we also gated by i_mem_ready); memory waits stall until ready or timeout trap.
module cpu_control_fsm #(
    parameter int TIMEOUT        = 255,
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [5:0]  i_op,
    input  logic        i_mem_ready,
    input  logic        i_jump_DV,
    output logic [31:0] o_alu_op,
    output logic        o_b_sel,
    output logic        o_ab_load,
    output logic        o_ir_load,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_addr_sel,
    output logic        o_rf_we,
    output logic        o_pc_load,
    output logic        o_pc_sel,
    output logic        o_busy,
    output logic        o_trap,
    output logic [31:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_RESOLVE, S_MEM, S_WRITEBACK, S_TRAP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_op;
    logic        r_jump_q;
    logic [15:0] r_wait;
    logic [31:0] r_retired;

    logic        w_is_alu;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_jump_wb;
    logic        w_wait_last;
    logic [31:0] w_alu_op;

    // Op class is taken from the copy latched in DECODE so later states do not depend on i_op staying put.
    assign w_is_alu     = (r_op <= 6'd26);
    assign w_is_load    = (r_op >= 6'd27) && (r_op <= 6'd31);
    assign w_is_store   = (r_op >= 6'd32) && (r_op <= 6'd34);
    assign w_is_jump_wb = (r_op >= 6'd41) && (r_op <= 6'd44);
    assign w_wait_last  = (r_wait == 16'(TIMEOUT - 1));
    assign o_retired    = r_retired;

    always_comb begin
        if (w_is_load)
            w_alu_op = 32'd18;
        else if (w_is_store)
            w_alu_op = 32'd0;
        else
            w_alu_op = {26'd0, r_op};
    end

    always_comb begin
        w_next         = r_state;
        o_alu_op       = 32'd0;
        o_b_sel        = 1'b0;
        o_ab_load      = 1'b0;
        o_ir_load      = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_rf_we        = 1'b0;
        o_pc_load      = 1'b0;
        o_pc_sel       = 1'b0;
        o_busy         = 1'b1;
        o_trap         = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_run)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_load = i_rst_n;
                    w_next    = S_DECODE;
                end else if (w_wait_last) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                o_ab_load = 1'b1;
                w_next    = (i_op >= 6'd45) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                o_alu_op = w_alu_op;
                o_b_sel  = w_is_store;
                w_next   = S_RESOLVE;
            end
            S_RESOLVE: begin
                o_alu_op = w_alu_op;
                w_next   = (w_is_load || w_is_store) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_mem_we       = w_is_store;
                if (i_mem_ready) begin
                    // Reset in the completion cycle abandons the load without a register write.
                    o_rf_we = w_is_load && i_rst_n;
                    w_next  = S_WRITEBACK;
                end else if (w_wait_last) begin
                    w_next = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                o_pc_load = 1'b1;
                o_pc_sel  = r_jump_q;
                o_rf_we   = w_is_alu || w_is_jump_wb;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                o_busy = 1'b0;
                o_trap = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= RESET_TO_FETCH ? S_FETCH : S_IDLE;
            r_op      <= 6'd0;
            r_jump_q  <= 1'b0;
            r_wait    <= 16'd0;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= i_op;
            if (r_state == S_RESOLVE)
                r_jump_q <= i_jump_DV;
            if (w_next != r_state)
                r_wait <= 16'd0;
            else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready)
                r_wait <= r_wait + 16'd1;
            if (r_state == S_WRITEBACK)
                r_retired <= r_retired + 32'd1;
        end
    end

endmodule
